// File: rtl/vector_dot_engine_pkg.sv
// Shared definitions for the fixed-point dot-product engine.
//   WORD_W / FRAC_W : operand and result word format (signed Q16.16)
//   ACC_W           : accumulator width, wide enough that no intermediate sum saturates
//   state_e         : engine FSM encoding
//   sat32()         : clamp a 64-bit accumulator into the signed 32-bit result range
package vector_dot_engine_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned FRAC_W = 16;
    localparam int unsigned ACC_W  = 64;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccum  = 2'd1,
        StFinish = 2'd2,
        StDone   = 2'd3
    } state_e;

    localparam logic signed [ACC_W-1:0] SatMax = 64'sh0000_0000_7FFF_FFFF;
    localparam logic signed [ACC_W-1:0] SatMin = 64'shFFFF_FFFF_8000_0000;

    function automatic logic [WORD_W-1:0] sat32(input logic signed [ACC_W-1:0] x);
        if (x > SatMax) begin
            return 32'h7FFF_FFFF;
        end else if (x < SatMin) begin
            return 32'h8000_0000;
        end else begin
            return x[WORD_W-1:0];
        end
    endfunction

endpackage

// File: rtl/vector_dot_engine_fxp_mul.sv
// Combinational signed Q16.16 multiplier lane.
//   a_i, b_i : signed Q16.16 operands
//   p_o      : full 64-bit product arithmetically shifted right by FRAC_W (rounds toward -inf)
module fxp_mul_q16
    import vector_dot_engine_pkg::*;
(
    input  logic signed [WORD_W-1:0] a_i,
    input  logic signed [WORD_W-1:0] b_i,
    output logic signed [ACC_W-1:0]  p_o
);

    logic signed [ACC_W-1:0] a_ext;
    logic signed [ACC_W-1:0] b_ext;
    logic signed [ACC_W-1:0] full;

    // Sign-extend first so the 64-bit product of two 32-bit values is exact.
    assign a_ext = ACC_W'(a_i);
    assign b_ext = ACC_W'(b_i);
    assign full  = a_ext * b_ext;
    assign p_o   = full >>> FRAC_W;

endmodule

// File: rtl/vector_dot_engine.sv
// Fixed-point dot-product engine.
//   clk, rst : clock and synchronous active-high reset
//   A, B     : operand vectors, element i at [32*i +: 32], signed Q16.16
//   vlen     : element count, clamped to BUFLEN
//   start    : request pulse, accepted only in idle/done
//   busy     : request in progress
//   result   : saturated signed Q16.16 dot product, valid while done
//   done     : held until the next accepted start or reset
module vector_dot_engine
    import vector_dot_engine_pkg::*;
#(
    parameter int unsigned BUFLEN    = 3,
    parameter int unsigned MOD_COUNT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WORD_W*BUFLEN-1:0] A,
    input  logic [WORD_W*BUFLEN-1:0] B,
    input  logic [31:0]              vlen,
    input  logic                     start,
    output logic                     busy,
    output logic [WORD_W-1:0]        result,
    output logic                     done
);

    state_e                    state_q, state_d;
    logic [WORD_W*BUFLEN-1:0]  a_q, a_d;
    logic [WORD_W*BUFLEN-1:0]  b_q, b_d;
    logic [31:0]               v_q, v_d;
    logic [31:0]               idx_q, idx_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [WORD_W-1:0]         result_q, result_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic [31:0]               v_clamped;
    logic signed [ACC_W-1:0]   lane_p [MOD_COUNT];
    logic signed [ACC_W-1:0]   lane_sum;

    assign v_clamped = (vlen > 32'(BUFLEN)) ? 32'(BUFLEN) : vlen;

    for (genvar j = 0; j < MOD_COUNT; j++) begin : g_lane
        logic [31:0]              pos;
        logic signed [WORD_W-1:0] ea;
        logic signed [WORD_W-1:0] eb;
        logic signed [ACC_W-1:0]  prod;

        assign pos = idx_q + 32'(j);

        // Mux by comparison so lanes running past BUFLEN never index out of range.
        always_comb begin
            ea = '0;
            eb = '0;
            for (int unsigned e = 0; e < BUFLEN; e++) begin
                if (pos == 32'(e)) begin
                    ea = a_q[e*WORD_W +: WORD_W];
                    eb = b_q[e*WORD_W +: WORD_W];
                end
            end
        end

        fxp_mul_q16 u_mul (
            .a_i (ea),
            .b_i (eb),
            .p_o (prod)
        );

        assign lane_p[j] = (pos < v_q) ? prod : '0;
    end

    always_comb begin
        lane_sum = '0;
        for (int unsigned j = 0; j < MOD_COUNT; j++) begin
            lane_sum = lane_sum + lane_p[j];
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        v_d      = v_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = done_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    v_d     = v_clamped;
                    idx_d   = '0;
                    acc_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = StAccum;
                end
            end
            StAccum: begin
                acc_d = acc_q + lane_sum;
                idx_d = idx_q + MOD_COUNT;
                // v=0 still takes one (fully masked) cycle here.
                if (idx_q + MOD_COUNT >= v_q) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                result_d = sat32(acc_q);
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            v_q      <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            v_q      <= v_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign result = result_q;
    assign done   = done_q;

endmodule

// File: tb/tb_vector_dot_engine.sv
module tb_vector_dot_engine;

    localparam int MCS [3] = '{1, 2, 3};

    typedef struct {
        logic [31:0] res;
        int          launch;
        int          v;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [95:0] a_bus;
    logic [95:0] b_bus;
    logic [31:0] vlen;
    logic        start;
    logic [2:0]  busy_w;
    logic [2:0]  done_w;
    logic [31:0] res_w [3];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb [$];
    int   rd [3] = '{0, 0, 0};
    int   busy_cnt [3] = '{0, 0, 0};
    bit   done_prev [3] = '{0, 0, 0};

    vector_dot_engine #(.BUFLEN(3), .MOD_COUNT(1)) u_mc1 (
        .clk(clk), .rst(rst), .A(a_bus), .B(b_bus), .vlen(vlen), .start(start),
        .busy(busy_w[0]), .result(res_w[0]), .done(done_w[0])
    );
    vector_dot_engine #(.BUFLEN(3), .MOD_COUNT(2)) u_mc2 (
        .clk(clk), .rst(rst), .A(a_bus), .B(b_bus), .vlen(vlen), .start(start),
        .busy(busy_w[1]), .result(res_w[1]), .done(done_w[1])
    );
    vector_dot_engine #(.BUFLEN(3), .MOD_COUNT(3)) u_mc3 (
        .clk(clk), .rst(rst), .A(a_bus), .B(b_bus), .vlen(vlen), .start(start),
        .busy(busy_w[2]), .result(res_w[2]), .done(done_w[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    function automatic int lat(input int v, input int mc);
        if (v == 0) return 1;
        return (v + mc - 1) / mc;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s dut_mc%0d: got %h want %h", name, MCS[k], got, want);
        end
    endtask

    // Monitor: on each done rising edge pop the next expectation for that DUT.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (busy_w[k] === 1'b1) busy_cnt[k]++;
            if (done_w[k] === 1'b1 && !done_prev[k]) begin
                checks++;
                if (rd[k] >= sb.size()) begin
                    errors++;
                    $display("FAIL unexpected_done dut_mc%0d: got done want none", MCS[k]);
                end else begin
                    exp_t e;
                    int   l;
                    e = sb[rd[k]];
                    rd[k]++;
                    l = lat(e.v, MCS[k]);
                    chk("result", k, res_w[k], e.res);
                    chk("done_edge", k, 32'(cyc), 32'(e.launch + l + 1));
                    chk("busy_cycles", k, 32'(busy_cnt[k]), 32'(l + 1));
                end
                busy_cnt[k] = 0;
            end
            if (busy_w[k] !== 1'b1 && done_w[k] !== 1'b1) busy_cnt[k] = 0;
            done_prev[k] = (done_w[k] === 1'b1);
        end
    end

    task automatic set_ops(input logic [31:0] a0, a1, a2, b0, b1, b2, input logic [31:0] vl);
        a_bus = {a2, a1, a0};
        b_bus = {b2, b1, b0};
        vlen  = vl;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic launch(input logic [31:0] exp_res, input bit push);
        exp_t e;
        e.res    = exp_res;
        e.launch = cyc + 1;
        e.v      = (vlen > 3) ? 3 : int'(vlen);
        if (push) sb.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_all_done();
        int n = 0;
        while (done_w !== 3'b111 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_w !== 3'b111) begin
            errors++;
            $display("FAIL wait_done: got done %b want 111", done_w);
        end
        @(negedge clk);
    endtask

    task automatic chk_idle_all(input string name);
        for (int k = 0; k < 3; k++) begin
            chk({name, "_busy"}, k, 32'(busy_w[k]), 32'd0);
            chk({name, "_done"}, k, 32'(done_w[k]), 32'd0);
            chk({name, "_result"}, k, res_w[k], 32'd0);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        set_ops('0, '0, '0, '0, '0, '0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk_idle_all("reset");
        rst = 1'b0;
        @(negedge clk);

        // 1*4 + 2*5 + 3*6 = 32
        set_ops(32'h0001_0000, 32'h0002_0000, 32'h0003_0000,
                32'h0004_0000, 32'h0005_0000, 32'h0006_0000, 32'd3);
        launch(32'h0020_0000, 1'b1);
        wait_all_done();

        // Third element is huge but masked: 4 + 10 = 14
        set_ops(32'h0001_0000, 32'h0002_0000, 32'h7FFF_FFFF,
                32'h0004_0000, 32'h0005_0000, 32'h7FFF_FFFF, 32'd2);
        launch(32'h000E_0000, 1'b1);
        wait_all_done();

        // vlen clamped to 3
        set_ops(32'h0001_0000, 32'h0002_0000, 32'h0003_0000,
                32'h0004_0000, 32'h0005_0000, 32'h0006_0000, 32'd7);
        launch(32'h0020_0000, 1'b1);
        wait_all_done();

        // vlen 0
        set_ops(32'h0001_0000, 32'h0002_0000, 32'h0003_0000,
                32'h0004_0000, 32'h0005_0000, 32'h0006_0000, 32'd0);
        launch(32'h0000_0000, 1'b1);
        wait_all_done();

        // 256*256 overflows positive
        set_ops(32'h0100_0000, '0, '0, 32'h0100_0000, '0, '0, 32'd1);
        launch(32'h7FFF_FFFF, 1'b1);
        wait_all_done();

        // -256*256 overflows negative
        set_ops(32'hFF00_0000, '0, '0, 32'h0100_0000, '0, '0, 32'd1);
        launch(32'h8000_0000, 1'b1);
        wait_all_done();

        // 0.5*-1 + -0.5*-1 = 0
        set_ops(32'h0000_8000, 32'hFFFF_8000, '0, 32'hFFFF_0000, 32'hFFFF_0000, '0, 32'd2);
        launch(32'h0000_0000, 1'b1);
        wait_all_done();

        // Start pulsed during ACCUM with altered operands: ignored, original result stands
        set_ops(32'h0001_0000, 32'h0002_0000, 32'h0003_0000,
                32'h0004_0000, 32'h0005_0000, 32'h0006_0000, 32'd3);
        launch(32'h0020_0000, 1'b1);
        set_ops(32'h0100_0000, 32'h0100_0000, '0, 32'h0100_0000, '0, '0, 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_all_done();

        // Restart from DONE: 2*1.5 + 3*-1 + 1*0.25 = 0.25; done must dip before rising
        set_ops(32'h0002_0000, 32'h0003_0000, 32'h0001_0000,
                32'h0001_8000, 32'hFFFF_0000, 32'h0000_4000, 32'd3);
        launch(32'h0000_4000, 1'b1);
        for (int k = 0; k < 3; k++) chk("done_drop", k, 32'(done_w[k]), 32'd0);
        wait_all_done();

        // Reset sampled at the second ACCUM edge aborts the run
        set_ops(32'h0001_0000, 32'h0002_0000, 32'h0003_0000,
                32'h0004_0000, 32'h0005_0000, 32'h0006_0000, 32'd3);
        launch(32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle_all("abort");
        @(negedge clk);
        chk_idle_all("abort_hold");

        // Complete a run, then reset and start together: reset wins
        launch(32'h0020_0000, 1'b1);
        wait_all_done();
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        chk_idle_all("rst_start");
        @(negedge clk);
        chk_idle_all("rst_start_hold");

        // Recovery after reset
        set_ops(32'h0001_0000, 32'h0002_0000, 32'h0003_0000,
                32'h0004_0000, 32'h0005_0000, 32'h0006_0000, 32'd3);
        launch(32'h0020_0000, 1'b1);
        wait_all_done();

        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) chk("sb_drained", k, 32'(rd[k]), 32'(sb.size()));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_dot_engine.md
# vector_dot_engine

Fixed-point dot-product engine answering requests from the matrix-multiplication controllers. A controller presents two operand vectors and a runtime length and pulses `start`. The engine then walks the vectors `MOD_COUNT` element pairs per cycle, accumulates the products, and returns one saturated 32-bit scalar with a held `done`. It is the responder side of the row-times-vector loop used by the NN layer datapath.

## Interface
- `BUFLEN`, default 3: maximum vector length in elements. Sizes the operand buses.
- `MOD_COUNT`, default 1: number of parallel multiplier lanes, i.e. element pairs consumed per cycle. Range 1..BUFLEN.
- `clk`  in  1: single clock; all logic on posedge.
- `rst`  in  1: synchronous, active-high reset.
- `A`  in  32*BUFLEN: operand vector. Element i is at bits [32*i +: 32]. Signed Q16.16.
- `B`  in  32*BUFLEN: operand vector, same layout and format as `A`.
- `vlen`  in  32: number of valid elements. Values above BUFLEN are clamped to BUFLEN.
- `start`  in  1: request pulse. Sampled only in IDLE or DONE.
- `busy`  out  1: high while a request is in progress.
- `result`  out  32: signed Q16.16 dot product. Valid while `done`=1.
- `done`  out  1: result valid. Held until the next accepted `start` or `rst`.

## Operation
- States: IDLE, ACCUM, FINISH, DONE.
- Reset: state=IDLE, `busy`=0, `done`=0, `result`=0, accumulator=0, index=0.
- **Start accepted** (IDLE or DONE, with `start`=1):
  - latch `A`, `B` and clamped `vlen` (call it v) into internal copies;
  - acc=0, idx=0, `busy`<=1, `done`<=0;
  - go to ACCUM.
- **ACCUM**, each cycle:
  - lane j (0..MOD_COUNT-1) computes the 64-bit signed product of elements idx+j, then arithmetic shift right by 16 (truncation toward -inf);
  - any lane with idx+j >= v contributes 0;
  - acc += sum of lane results; idx += MOD_COUNT;
  - when idx+MOD_COUNT >= v, go to FINISH.
- **FINISH:**
  - `result` <= acc saturated to [0x80000000, 0x7FFFFFFF];
  - `done`<=1, `busy`<=0; go to DONE.
- **DONE:** hold `result` and `done`. A new `start` behaves as from IDLE.
- Arithmetic widths: accumulator is 64-bit signed; no intermediate saturation, only at FINISH.
- `start` during ACCUM or FINISH is ignored. Changes on `A`, `B` or `vlen` after acceptance have no effect, because the latched copies are used.
- v=0: one ACCUM cycle with all lanes masked, then `result`=0.

## Timing
- K = max(1, ceil(v/MOD_COUNT)) ACCUM cycles.
- Start sampled at edge 0 → `busy` high after edge 0 → `done` rises and `result` updates at edge K+1. `busy` falls at the same edge.
- Back-to-back: `start` held high in DONE re-launches at that edge. `done` drops the following cycle, so it is never high across two requests without a low cycle in between.
- `rst` wins over everything, including a same-cycle `start`. Reset in the middle of ACCUM aborts the request: next cycle `busy`=0, `done`=0, `result`=0.

## Structure
- Shared package holds:
  - `WORD_W`=32, `FRAC_W`=16, `ACC_W`=64;
  - the state encoding (2-bit: IDLE=0, ACCUM=1, FINISH=2, DONE=3);
  - the saturate-to-32 function.
- One sub-module, `fxp_mul_q16`: combinational signed 32x32 multiply with the >>>16 shift, 64-bit output. Instantiated MOD_COUNT times in a generate loop.
- Lane masking and the adder tree live in the top module.

## Test plan
- BUFLEN=3, MOD_COUNT=1; A={1.0,2.0,3.0}=0x00010000/0x00020000/0x00030000; B={4.0,5.0,6.0}; vlen=3; start → `result`=0x00200000 (32.0), `done` at edge 4, `busy` high for edges 1..3 (cycles between edges 0 and 4).
- Same operands, MOD_COUNT=2 → `result`=0x00200000, `done` at edge 3. MOD_COUNT=3 → `done` at edge 2.
- vlen=2 with A[2]=B[2]=0x7FFFFFFF → `result`=0x000E0000 (14.0). vlen=7 clamped to 3 → 0x00200000. vlen=0 → `result`=0, `done` at edge 2.
- Saturation: A={256.0, 0, 0}=0x01000000, B same, vlen=1 → 0x7FFFFFFF. A[0]=-256.0 (0xFF000000) → 0x80000000. A={0.5,-0.5}, B={-1.0,-1.0}, vlen=2 → 0x00000000.
- Protocol: `start` pulsed again during ACCUM → ignored, original result returned. Operand change after acceptance → no effect. `start` held high in DONE → `done` low one cycle, then new result.
- Reset: `rst` asserted at ACCUM edge 2 of a vlen=3 run → next cycle `busy`=0, `done`=0, `result`=0. `rst`+`start` in the same cycle → remains IDLE.
